pwm_gen: RTL

PWM output stage of the generator. Consumes the free-running `count_val` produced by the timer counter and converts it into a PWM waveform. Shadow registers let compare, alignment and polarity settings change glitch-free at period boundaries. Sits between the counter and the device pin, beside the register file that supplies its configuration.

---
 rtl/pwm_gen.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/pwm_gen.sv
// PWM output stage: wrap detection, glitch-free shadowed compare/alignment/polarity, registered output.
// Define PWM_DEADTIME_EN to add the complementary output pwm_out_n with a dead-time FSM.
module pwm_gen #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_en,
    input  logic [WIDTH-1:0] count_val,
    input  logic [WIDTH-1:0] period,
    input  logic             upnotdown,
    input  logic [WIDTH-1:0] compare1,
    input  logic [WIDTH-1:0] compare2,
    input  logic [1:0]       align_mode,
    input  logic             polarity,
    input  logic             update_req,
    output logic             pwm_out,
    output logic             period_event,
    output logic             shadow_pending
`ifdef PWM_DEADTIME_EN
    ,
    output logic             pwm_out_n,
    input  logic [7:0]       deadtime
`endif
);

    localparam int unsigned DT_W        = 8;
    localparam logic [1:0]  ALIGN_LEFT  = 2'b00;
    localparam logic [1:0]  ALIGN_RIGHT = 2'b01;
    localparam logic [1:0]  ALIGN_UNAL  = 2'b10;

    logic [WIDTH-1:0] r_prev_count;
    logic [WIDTH-1:0] r_c1s;
    logic [WIDTH-1:0] r_c2s;
    logic [1:0]       r_ams;
    logic             r_pols;
    logic             r_pending;

    logic             w_wrap;
    logic             w_load;
    logic [WIDTH-1:0] w_c1s;
    logic [WIDTH-1:0] w_c2s;
    logic [1:0]       w_ams;
    logic             w_pols;
    logic             w_pending_nxt;
    logic             w_raw;
    logic             w_pwm_nxt;

    // A held count never re-triggers; a jump onto the wrap value from elsewhere does.
    always_comb begin
        w_wrap = 1'b0;
        if (count_val != r_prev_count) begin
            w_wrap = upnotdown ? (count_val == '0) : (count_val == period);
        end
    end

    assign w_load = !pwm_en || (w_wrap && (r_pending || update_req));

    // Shadow values valid after this edge; the waveform uses them directly.
    assign w_c1s  = w_load ? compare1   : r_c1s;
    assign w_c2s  = w_load ? compare2   : r_c2s;
    assign w_ams  = w_load ? align_mode : r_ams;
    assign w_pols = w_load ? polarity   : r_pols;

    always_comb begin
        w_pending_nxt = r_pending;
        if (w_load) begin
            w_pending_nxt = 1'b0;
        end else if (update_req) begin
            w_pending_nxt = 1'b1;
        end
    end

    always_comb begin
        w_raw = 1'b0;
        case (w_ams)
            ALIGN_LEFT:  w_raw = (count_val < w_c1s);
            ALIGN_RIGHT: w_raw = (count_val >= w_c1s);
            ALIGN_UNAL:  w_raw = (count_val >= w_c1s) && (count_val < w_c2s);
            default:     w_raw = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_count   <= '0;
            r_c1s          <= '0;
            r_c2s          <= '0;
            r_ams          <= '0;
            r_pols         <= 1'b0;
            r_pending      <= 1'b0;
            period_event   <= 1'b0;
            shadow_pending <= 1'b0;
        end else begin
            r_prev_count   <= count_val;
            r_c1s          <= w_c1s;
            r_c2s          <= w_c2s;
            r_ams          <= w_ams;
            r_pols         <= w_pols;
            r_pending      <= w_pending_nxt;
            period_event   <= w_wrap;
            shadow_pending <= w_pending_nxt;
        end
    end

`ifdef PWM_DEADTIME_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HI   = 2'b01,
        ST_LO   = 2'b10,
        ST_DT   = 2'b11
    } dt_state_e;

    dt_state_e        r_state;
    dt_state_e        w_state_nxt;
    logic [DT_W-1:0]  r_dt_cnt;
    logic [DT_W-1:0]  w_dt_cnt_nxt;
    logic             w_pwm_n_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_dt_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_dt_cnt <= w_dt_cnt_nxt;
        end
    end

    // Dead-time sequencing; outputs are decoded from the next state so they register with it.
    always_comb begin
        w_state_nxt  = r_state;
        w_dt_cnt_nxt = r_dt_cnt;
        w_pwm_nxt    = w_pols;
        w_pwm_n_nxt  = w_pols;
        if (!pwm_en) begin
            w_state_nxt  = ST_IDLE;
            w_dt_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt  = w_raw ? ST_HI : ST_LO;
                    w_dt_cnt_nxt = '0;
                end
                ST_HI: begin
                    if (!w_raw) begin
                        if (deadtime == '0) begin
                            w_state_nxt = ST_LO;
                        end else begin
                            w_state_nxt  = ST_DT;
                            w_dt_cnt_nxt = deadtime;
                        end
                    end
                end
                ST_LO: begin
                    if (w_raw) begin
                        if (deadtime == '0) begin
                            w_state_nxt = ST_HI;
                        end else begin
                            w_state_nxt  = ST_DT;
                            w_dt_cnt_nxt = deadtime;
                        end
                    end
                end
                ST_DT: begin
                    if (r_dt_cnt <= DT_W'(1)) begin
                        w_state_nxt  = w_raw ? ST_HI : ST_LO;
                        w_dt_cnt_nxt = '0;
                    end else begin
                        w_dt_cnt_nxt = r_dt_cnt - DT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_dt_cnt_nxt = '0;
                end
            endcase
        end
        if (w_state_nxt == ST_HI) begin
            w_pwm_nxt = !w_pols;
        end
        if (w_state_nxt == ST_LO) begin
            w_pwm_n_nxt = !w_pols;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out   <= 1'b0;
            pwm_out_n <= 1'b0;
        end else begin
            pwm_out   <= w_pwm_nxt;
            pwm_out_n <= w_pwm_n_nxt;
        end
    end
`else
    assign w_pwm_nxt = pwm_en ? (w_raw ^ w_pols) : polarity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= w_pwm_nxt;
        end
    end
`endif

endmodule
